// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_pkg;

    // Width of the internal h/v counters and of the pixel coordinate outputs.
    localparam int CNT_W = 10;

    typedef logic [7:0] rgb8_t;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    // RRRGGGBB palette.
    localparam rgb8_t WHITE   = 8'hFF;
    localparam rgb8_t YELLOW  = 8'hFC;
    localparam rgb8_t CYAN    = 8'h1F;
    localparam rgb8_t GREEN   = 8'h1C;
    localparam rgb8_t MAGENTA = 8'hE3;
    localparam rgb8_t RED     = 8'hE0;
    localparam rgb8_t BLUE    = 8'h03;
    localparam rgb8_t BLACK   = 8'h00;

    // Colour of bar idx, left to right.
    function automatic rgb8_t bar_color(input logic [2:0] idx);
        rgb8_t c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, h/v raster counters and raw sync/active decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             pix_en_o,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             hsync_act_o,
    output logic             vsync_act_o,
    output logic             active_o,
    output logic             line_end_o,
    output logic             frame_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             pix_en;

    assign pix_en = (div_q == DIV_LAST);

    // Next-state for the divider and the raster counters.
    always_comb begin
        div_d = pix_en ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign pix_en_o    = pix_en;
    assign h_cnt_o     = h_q;
    assign v_cnt_o     = v_q;
    assign hsync_act_o = (h_q >= HS_START) && (h_q < HS_END);
    assign vsync_act_o = (v_q >= VS_START) && (v_q < VS_END);
    assign active_o    = (h_q < H_ACT) && (v_q < V_ACT);
    assign line_end_o  = pix_en && (h_q == H_LAST);
    assign frame_end_o = pix_en && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: mode latch, bouncing box, pattern mux and
// registered output stage on top of vga_timing.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int    PIX_DIV     = 2,
    parameter int    H_ACTIVE    = 640,
    parameter int    H_FP        = 16,
    parameter int    H_SYNC      = 96,
    parameter int    H_BP        = 48,
    parameter int    V_ACTIVE    = 480,
    parameter int    V_FP        = 10,
    parameter int    V_SYNC      = 2,
    parameter int    V_BP        = 33,
    parameter logic  SYNC_POL    = 1'b0,
    parameter rgb8_t SOLID_COLOR = 8'hFF,
    parameter int    CHECK_LOG2  = 5,
    parameter int    BOX_SIZE    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgbcolor,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int SEG_LEN = H_ACTIVE / 8;
    localparam int SEG_W   = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_LEN - 1);
    localparam logic [CNT_W-1:0] BX_MAX   = CNT_W'(H_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W-1:0] BY_MAX   = CNT_W'(V_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX_W    = CNT_W'(BOX_SIZE);

    logic             pix_en;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_act;
    logic             vs_act;
    logic             active;
    logic             line_end;
    logic             frame_end;

    vga_timing #(
        .PIX_DIV  (PIX_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i       (clk),
        .rst_i       (reset),
        .pix_en_o    (pix_en),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .hsync_act_o (hs_act),
        .vsync_act_o (vs_act),
        .active_o    (active),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] bx_q, bx_d, by_q, by_d;
    logic             dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards larger coordinate
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [2:0]       bar_q, bar_d;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    rgb8_t            rgb_q, rgb_d;
    logic [CNT_W-1:0] px_q, px_d;
    logic [CNT_W-1:0] py_q, py_d;
    logic             fs_q, fs_d;

    logic             in_box;
    rgb8_t            pattern;

    // Mode latch and bar segment tracking; both follow the raster counters.
    always_comb begin
        mode_d = frame_end ? mode_e'(mode) : mode_q;
        seg_d  = seg_q;
        bar_d  = bar_q;
        if (line_end) begin
            seg_d = '0;
            bar_d = '0;
        end else if (pix_en) begin
            if (seg_q == SEG_LAST) begin
                seg_d = '0;
                bar_d = bar_q + 1'b1;
            end else begin
                seg_d = seg_q + 1'b1;
            end
        end
    end

    // Box motion: one step per axis at end of frame. The box only advances
    // after a frame that actually displayed it, so the first box frame
    // following a mode switch starts from the stored position.
    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (frame_end && (mode_q == MODE_BOX)) begin
            if (dx_q) begin
                if (bx_q == BX_MAX) begin
                    bx_d = bx_q - 1'b1;
                    dx_d = 1'b0;
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end else begin
                if (bx_q == '0) begin
                    bx_d = bx_q + 1'b1;
                    dx_d = 1'b1;
                end else begin
                    bx_d = bx_q - 1'b1;
                end
            end
            if (dy_q) begin
                if (by_q == BY_MAX) begin
                    by_d = by_q - 1'b1;
                    dy_d = 1'b0;
                end else begin
                    by_d = by_q + 1'b1;
                end
            end else begin
                if (by_q == '0) begin
                    by_d = by_q + 1'b1;
                    dy_d = 1'b1;
                end else begin
                    by_d = by_q - 1'b1;
                end
            end
        end
    end

    // Pattern colour for the current counter position.
    always_comb begin
        in_box  = (h_cnt >= bx_q) && (h_cnt < bx_q + BOX_W) &&
                  (v_cnt >= by_q) && (v_cnt < by_q + BOX_W);
        pattern = BLACK;
        if (active) begin
            case (mode_q)
                MODE_SOLID: pattern = SOLID_COLOR;
                MODE_BARS:  pattern = bar_color(bar_q);
                MODE_CHECK: pattern = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? WHITE : BLACK;
                default:    pattern = in_box ? RED : BLUE;
            endcase
        end
    end

    // Output stage: captures the current counter state on each pixel tick.
    always_comb begin
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        rgb_d      = rgb_q;
        px_d       = px_q;
        py_d       = py_q;
        fs_d       = pix_en && (h_cnt == '0) && (v_cnt == '0);
        if (pix_en) begin
            hsync_d    = hs_act ? SYNC_POL : ~SYNC_POL;
            vsync_d    = vs_act ? SYNC_POL : ~SYNC_POL;
            video_on_d = active;
            rgb_d      = pattern;
            px_d       = h_cnt;
            py_d       = v_cnt;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_SOLID;
            bx_q       <= '0;
            by_q       <= '0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            seg_q      <= '0;
            bar_q      <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            video_on_q <= 1'b0;
            rgb_q      <= BLACK;
            px_q       <= '0;
            py_q       <= '0;
            fs_q       <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            seg_q      <= seg_d;
            bar_q      <= bar_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            rgb_q      <= rgb_d;
            px_q       <= px_d;
            py_q       <= py_d;
            fs_q       <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgbcolor    = rgb_q;
    assign video_on    = video_on_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign frame_start = fs_q;

endmodule
